// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// A controller raises start with an operand pair while busy is low; W clocks
// later done pulses for one cycle with the registered quotient and remainder.
// A zero divisor is answered on the start edge itself with quotient all-ones,
// remainder equal to the dividend and div_by_zero set.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        division request, sampled only while busy is low
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high while an iteration sequence is running
//   done         one-cycle pulse marking a result update
//   quotient     registered quotient, held until the next result
//   remainder    registered remainder, held until the next result
//   div_by_zero  registered flag, set when the last result had a zero divisor

module seq_restoring_divider #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LastCnt = CW'(W - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  divisor_q, divisor_d;
    logic [W-1:0]  q_sr_q, q_sr_d;
    // The partial remainder is conceptually W+1 bits, but after the restore
    // step it is always below the divisor, so its top bit is always zero and
    // is not stored.
    logic [W-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          done_q, done_d;

    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic [W-1:0]  q_next;
    logic [W-1:0]  rem_next;

    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        q_sr_d      = q_sr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        // One restoring step: bring in the next dividend bit, try to subtract,
        // keep the difference only when it did not borrow.
        shifted  = {rem_q, q_sr_q[W-1]};
        trial    = shifted - {1'b0, divisor_q};
        q_next   = {q_sr_q[W-2:0], ~trial[W]};
        rem_next = trial[W] ? shifted[W-1:0] : trial[W-1:0];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        divisor_d = divisor;
                        q_sr_d    = dividend;
                        rem_d     = '0;
                        cnt_d     = '0;
                        state_d   = StRun;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            StRun: begin
                q_sr_d = q_next;
                rem_d  = rem_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    quotient_d  = q_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            divisor_q   <= '0;
            q_sr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            q_sr_q      <= q_sr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider at W=4: directed table,
// hand-written handshake/reset sequences, exhaustive and random sweeps
// against an arithmetic reference model.

module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[6];

    seq_restoring_divider #(.W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all-ones quotient.
    task automatic ref_div(input int a, input int b, output int q, output int r,
                           output int z);
        if (b == 0) begin
            q = 15; r = a; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endtask

    // Issues one start from the current sample point and waits for done.
    // Returns at #1 after the done edge, so a following call starts in the
    // done cycle. With glitch set, a 1/1 start is pulsed while busy.
    task automatic run_div(input int a, input int b, input bit glitch,
                           output int lat, output int busy_cnt, output bit ok);
        dividend = 4'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        lat = 0; busy_cnt = 0; ok = 1'b1;
        while (!done) begin
            if (lat >= 20) begin
                ok = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            if (glitch && lat == 1) begin
                start = 1'b1; dividend = 4'd1; divisor = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic do_check(input string name, input int a, input int b, input bit glitch,
                            input int eq, input int er, input int ez);
        int lat, bc;
        bit ok;
        run_div(a, b, glitch, lat, bc, ok);
        if (!ok) $display("FAIL %s timeout: a=%0d b=%0d no done seen", name, a, b);
        check({name, " done_seen"}, int'(ok), 1);
        if (!ok) return;
        if (int'(quotient) != eq || int'(remainder) != er || int'(div_by_zero) != ez)
            $display("  operands a=%0d b=%0d", a, b);
        check({name, " quotient"}, int'(quotient), eq);
        check({name, " remainder"}, int'(remainder), er);
        check({name, " div_by_zero"}, int'(div_by_zero), ez);
        check({name, " latency"}, lat, (b == 0) ? 0 : 4);
        check({name, " busy_cycles"}, bc, (b == 0) ? 0 : 4);
        check({name, " busy_in_done"}, int'(busy), 0);
        if (b != 0) begin
            check({name, " invariant"}, int'(quotient) * b + int'(remainder), a);
            check({name, " rem_lt_div"}, int'(int'(remainder) < b), 1);
        end
    endtask

    initial begin
        int q, r, z, dones;

        vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, z: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
        vecs[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, z: 1'b0};
        vecs[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
        vecs[4] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};
        vecs[5] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, z: 1'b0};

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 13/4 with done held for exactly one cycle and results held after it.
        do_check("13/4", 13, 4, 1'b0, 3, 1, 0);
        @(posedge clk); #1;
        check("13/4 done_one_cycle", int'(done), 0);
        check("13/4 quotient_held", int'(quotient), 3);
        check("13/4 remainder_held", int'(remainder), 1);

        // Directed table, back-to-back (each start lands in the previous done cycle).
        for (int i = 0; i < 6; i++)
            do_check($sformatf("vec%0d", i), int'(vecs[i].a), int'(vecs[i].b), 1'b0,
                     int'(vecs[i].q), int'(vecs[i].r), int'(vecs[i].z));

        // Mid-run start ignored, then 7/2 issued in the done cycle.
        @(posedge clk); #1;
        do_check("12/5 glitch", 12, 5, 1'b1, 2, 2, 0);
        do_check("7/2 after_done", 7, 2, 1'b0, 3, 1, 0);

        // Reset two cycles into a 14/3 run.
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset quotient", int'(quotient), 0);
        check("midreset remainder", int'(remainder), 0);
        check("midreset div_by_zero", int'(div_by_zero), 0);
        dones = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("midreset no_done_or_busy", dones, 0);
        do_check("6/4 after_reset", 6, 4, 1'b0, 1, 2, 0);

        // Exhaustive back-to-back sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_div(a, b, q, r, z);
                do_check("exh", a, b, 1'b0, q, r, z);
            end
        end

        // Random sweep with occasional idle gaps.
        for (int i = 0; i < 60; i++) begin
            int a, b;
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) begin
                @(posedge clk); #1;
            end
            ref_div(a, b, q, r, z);
            do_check("rand", a, b, ($urandom_range(1, 0) == 1), q, r, z);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
